// File: rtl/es9821q_init_sequencer_pkg.sv
// es9821q_init_sequencer_pkg: register table, FSM encoding and delay helper shared by the ES9821Q init path
// Contents: NUM_REGS/IDX_W sizing, the {reg,data} table entries, DEV_ADDR default,
// the sequencer state type and a microsecond-to-clock conversion.
package es9821q_init_sequencer_pkg;

    localparam int NUM_REGS = 4;
    localparam int IDX_W    = $clog2(NUM_REGS + 1);

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h40;

    // {reg_addr, wr_data}
    localparam logic [15:0] REG_ENTRY_0 = {8'h01, 8'h3C};
    localparam logic [15:0] REG_ENTRY_1 = {8'h02, 8'hA5};
    localparam logic [15:0] REG_ENTRY_2 = {8'h10, 8'h5A};
    localparam logic [15:0] REG_ENTRY_3 = {8'h2F, 8'hC3};

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_HOLD,
        S_PWR_WAIT,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    // Clamped to at least one clock so the "limit minus one" compare never wraps.
    function automatic logic [31:0] us_to_clks(input int unsigned us, input int unsigned hz);
        logic [63:0] t;
        t = (64'(us) * 64'(hz)) / 64'd1_000_000;
        return (t == 64'd0) ? 32'd1 : t[31:0];
    endfunction

endpackage

// File: rtl/es9821q_init_sequencer_reg_rom.sv
// es9821q_init_sequencer_reg_rom: registered lookup of the ES9821Q init register table
// Ports: i_clk clock; i_idx table index; o_reg_addr/o_wr_data entry fields, valid one clock after i_idx.
// Indices past the table read as zero.
module es9821q_init_sequencer_reg_rom
    import es9821q_init_sequencer_pkg::*;
(
    input  logic             i_clk,
    input  logic [IDX_W-1:0] i_idx,
    output logic [7:0]       o_reg_addr,
    output logic [7:0]       o_wr_data
);

    logic [15:0] r_entry;

    always_ff @(posedge i_clk) begin
        case (i_idx)
            IDX_W'(0): r_entry <= REG_ENTRY_0;
            IDX_W'(1): r_entry <= REG_ENTRY_1;
            IDX_W'(2): r_entry <= REG_ENTRY_2;
            IDX_W'(3): r_entry <= REG_ENTRY_3;
            default:   r_entry <= 16'h0000;
        endcase
    end

    assign o_reg_addr = r_entry[15:8];
    assign o_wr_data  = r_entry[7:0];

endmodule

// File: rtl/es9821q_init_sequencer.sv
// es9821q_init_sequencer: resets the ES9821Q, waits out power-up, then writes its register table over I2C with retry
// Ports:
//   i_clk, i_rst (sync, active high), i_start (rerun pulse, ignored while busy)
//   o_i2c_req pulse with o_i2c_dev_addr/o_i2c_reg_addr/o_i2c_wr_data held until the next request
//   i_i2c_busy, i_i2c_done, i_i2c_ack_error from the byte-write engine
//   o_adc_rst_n, o_init_busy, o_init_done (sticky), o_init_error (sticky), o_err_index
// All delay parameters must be at least one clock.
module es9821q_init_sequencer
    import es9821q_init_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 27_000_000,
    parameter int unsigned RST_HOLD_US    = 1000,
    parameter int unsigned PWRUP_US       = 10000,
    parameter int unsigned GAP_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [6:0]  DEV_ADDR       = DEV_ADDR_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_i2c_req,
    output logic [6:0] o_i2c_dev_addr,
    output logic [7:0] o_i2c_reg_addr,
    output logic [7:0] o_i2c_wr_data,
    input  logic       i_i2c_busy,
    input  logic       i_i2c_done,
    input  logic       i_i2c_ack_error,
    output logic       o_adc_rst_n,
    output logic       o_init_busy,
    output logic       o_init_done,
    output logic       o_init_error,
    output logic [7:0] o_err_index
);

    localparam logic [31:0] RST_HOLD_LIM = us_to_clks(RST_HOLD_US, CLK_FREQ_HZ) - 32'd1;
    localparam logic [31:0] PWRUP_LIM    = us_to_clks(PWRUP_US, CLK_FREQ_HZ) - 32'd1;
    localparam logic [31:0] GAP_LIM      = 32'(GAP_CYCLES) - 32'd1;
    localparam logic [31:0] TIMEOUT_LIM  = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t           r_state;
    logic [31:0]      r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_retry;
    logic             r_req;
    logic [7:0]       r_reg_addr;
    logic [7:0]       r_wr_data;
    logic             r_adc_rst_n;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [7:0]       r_err_index;

    logic [7:0]       w_rom_reg;
    logic [7:0]       w_rom_data;
    logic [31:0]      w_lim;
    logic             w_hit;

    es9821q_init_sequencer_reg_rom u_rom (
        .i_clk      (i_clk),
        .i_idx      (r_idx),
        .o_reg_addr (w_rom_reg),
        .o_wr_data  (w_rom_data)
    );

    // One shared counter; its terminal value depends on which wait is running.
    always_comb begin
        w_lim = (r_state == S_RST_HOLD) ? RST_HOLD_LIM :
                (r_state == S_PWR_WAIT) ? PWRUP_LIM    :
                (r_state == S_GAP)      ? GAP_LIM      : TIMEOUT_LIM;
        w_hit = (r_cnt == w_lim);
    end

    // The counter free-runs and is zeroed on every entry to a timed state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_RST_HOLD;
            r_cnt       <= 32'd0;
            r_idx       <= '0;
            r_retry     <= 8'd0;
            r_req       <= 1'b0;
            r_reg_addr  <= 8'd0;
            r_wr_data   <= 8'd0;
            r_adc_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= 8'd0;
        end else begin
            r_req <= 1'b0;
            r_cnt <= r_cnt + 32'd1;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_RST_HOLD;
                        r_cnt       <= 32'd0;
                        r_adc_rst_n <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_index <= 8'd0;
                    end
                end
                S_RST_HOLD: begin
                    if (w_hit) begin
                        r_state     <= S_PWR_WAIT;
                        r_cnt       <= 32'd0;
                        r_adc_rst_n <= 1'b1;
                    end
                end
                S_PWR_WAIT: begin
                    if (w_hit) begin
                        r_state <= S_FETCH;
                        r_idx   <= '0;
                        r_retry <= 8'd0;
                    end
                end
                S_FETCH: r_state <= S_ISSUE;
                S_ISSUE: begin
                    if (!i_i2c_busy) begin
                        r_state    <= S_WAIT;
                        r_req      <= 1'b1;
                        r_reg_addr <= w_rom_reg;
                        r_wr_data  <= w_rom_data;
                        r_cnt      <= 32'd0;
                    end
                end
                S_WAIT: begin
                    // A done on the expiry clock still wins over the timeout.
                    if (i_i2c_done && !i_i2c_ack_error) begin
                        r_state <= S_GAP;
                        r_idx   <= r_idx + IDX_W'(1);
                        r_retry <= 8'd0;
                        r_cnt   <= 32'd0;
                    end else if (i_i2c_done || w_hit) begin
                        r_cnt <= 32'd0;
                        if (r_retry < 8'(MAX_RETRY)) begin
                            r_state <= S_GAP;
                            r_retry <= r_retry + 8'd1;
                        end else begin
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_GAP: begin
                    if (w_hit)
                        r_state <= (r_idx == IDX_W'(NUM_REGS)) ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                S_ERROR: begin
                    r_state     <= S_IDLE;
                    r_error     <= 1'b1;
                    r_err_index <= 8'(r_idx);
                    r_busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_i2c_req      = r_req;
    assign o_i2c_dev_addr = DEV_ADDR;
    assign o_i2c_reg_addr = r_reg_addr;
    assign o_i2c_wr_data  = r_wr_data;
    assign o_adc_rst_n    = r_adc_rst_n;
    assign o_init_busy    = r_busy;
    assign o_init_done    = r_done;
    assign o_init_error   = r_error;
    assign o_err_index    = r_err_index;

endmodule

// File: tb/tb_es9821q_init_sequencer.sv
// tb_es9821q_init_sequencer: directed bench with a behavioural I2C engine for the ES9821Q init sequencer
module tb_es9821q_init_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       i2c_busy = 1'b0;
    logic       i2c_done = 1'b0;
    logic       i2c_ack_error = 1'b0;
    logic       i2c_req;
    logic [6:0] i2c_dev_addr;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_wr_data;
    logic       adc_rst_n;
    logic       init_busy;
    logic       init_done;
    logic       init_error;
    logic [7:0] err_index;

    always #5 clk = ~clk;

    es9821q_init_sequencer #(
        .CLK_FREQ_HZ    (1_000_000),
        .RST_HOLD_US    (2),
        .PWRUP_US       (4),
        .GAP_CYCLES     (3),
        .TIMEOUT_CYCLES (50),
        .MAX_RETRY      (3),
        .DEV_ADDR       (7'h40)
    ) u_dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .o_i2c_req       (i2c_req),
        .o_i2c_dev_addr  (i2c_dev_addr),
        .o_i2c_reg_addr  (i2c_reg_addr),
        .o_i2c_wr_data   (i2c_wr_data),
        .i_i2c_busy      (i2c_busy),
        .i_i2c_done      (i2c_done),
        .i_i2c_ack_error (i2c_ack_error),
        .o_adc_rst_n     (adc_rst_n),
        .o_init_busy     (init_busy),
        .o_init_done     (init_done),
        .o_init_error    (init_error),
        .o_err_index     (err_index)
    );

    logic [7:0] exp_reg  [4] = '{8'h01, 8'h02, 8'h10, 8'h2F};
    logic [7:0] exp_data [4] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int cyc = 0;
    int bcnt = 0;
    int nack_left [4] = '{0, 0, 0, 0};
    bit hang = 1'b0;
    bit nack_next = 1'b0;
    int last_done_cyc = 0;
    int adc_rise_cyc = 0;
    logic adc_prev = 1'b0;
    logic req_prev = 1'b0;
    int dbl_req = 0;
    int m_ent;
    int log_ent [$];
    int log_dat [$];
    int log_cyc [$];
    int log_gap [$];
    int exp_q [$];

    task automatic chk(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Engine model: busy for 20 clocks after each request, then a one-clock done.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            i2c_done = 1'b0;
            i2c_ack_error = 1'b0;
            if (adc_rst_n && !adc_prev) adc_rise_cyc = cyc;
            adc_prev = adc_rst_n;
            if (i2c_req && req_prev) dbl_req++;
            req_prev = i2c_req;
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    i2c_busy = 1'b0;
                    if (!hang) begin
                        i2c_done = 1'b1;
                        i2c_ack_error = nack_next;
                        last_done_cyc = cyc;
                    end
                end
            end
            if (i2c_req) begin
                m_ent = -1;
                for (int e = 0; e < 4; e++) if (exp_reg[e] == i2c_reg_addr) m_ent = e;
                log_ent.push_back(m_ent);
                log_dat.push_back(int'(i2c_wr_data));
                log_cyc.push_back(cyc);
                log_gap.push_back(cyc - last_done_cyc);
                nack_next = 1'b0;
                if (m_ent >= 0 && nack_left[m_ent] > 0) begin
                    nack_next = 1'b1;
                    nack_left[m_ent]--;
                end
                i2c_busy = 1'b1;
                bcnt = 20;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        log_ent.delete();
        log_dat.delete();
        log_cyc.delete();
        log_gap.delete();
    endtask

    task automatic start_reset(input string t);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({t, "_rst_adc"}, int'(adc_rst_n), 0);
        chk({t, "_rst_req"}, int'(i2c_req), 0);
        chk({t, "_rst_reg"}, int'(i2c_reg_addr), 0);
        chk({t, "_rst_data"}, int'(i2c_wr_data), 0);
        chk({t, "_rst_busy"}, int'(init_busy), 1);
        chk({t, "_rst_flags"}, int'({init_done, init_error}), 0);
        chk({t, "_rst_eidx"}, int'(err_index), 0);
        clear_logs();
        hang = 1'b0;
        nack_left = '{0, 0, 0, 0};
    endtask

    task automatic count_hold(input string t);
        int n = 0;
        while (adc_rst_n == 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({t, "_hold"}, n, 2);
    endtask

    task automatic release_rst(input string t);
        rst = 1'b0;
        count_hold(t);
    endtask

    task automatic wait_idle(input string t);
        int n = 0;
        @(negedge clk);
        while (init_busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk({t, "_idle"}, int'(init_busy), 0);
    endtask

    // gap_mode 1: done-to-next-req spacing; 2: req-to-req spacing after a timeout.
    task automatic check_log(input string t, input int gap_mode);
        int n;
        chk({t, "_nreq"}, log_ent.size(), exp_q.size());
        n = (log_ent.size() < exp_q.size()) ? log_ent.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_ent%0d", t, i), log_ent[i], exp_q[i]);
            chk($sformatf("%s_dat%0d", t, i), log_dat[i], int'(exp_data[exp_q[i]]));
            if (gap_mode == 1 && i > 0) chk($sformatf("%s_gap%0d", t, i), log_gap[i], 6);
            if (gap_mode == 2 && i > 0) chk($sformatf("%s_tmo%0d", t, i), log_cyc[i] - log_cyc[i-1], 55);
        end
    endtask

    initial begin
        int n;
        // 1: power-on, all ACK
        start_reset("t1");
        release_rst("t1");
        wait_idle("t1");
        exp_q = '{0, 1, 2, 3};
        check_log("t1", 1);
        chk("t1_first_lat", log_cyc.size() > 0 ? log_cyc[0] - adc_rise_cyc : -1, 6);
        chk("t1_done", int'(init_done), 1);
        chk("t1_error", int'(init_error), 0);
        chk("t1_adc", int'(adc_rst_n), 1);
        chk("t1_dev", int'(i2c_dev_addr), 'h40);

        // 2: entry 2 NACKed twice, then ACK
        start_reset("t2");
        nack_left[2] = 2;
        release_rst("t2");
        wait_idle("t2");
        exp_q = '{0, 1, 2, 2, 2, 3};
        check_log("t2", 1);
        chk("t2_done", int'(init_done), 1);
        chk("t2_error", int'(init_error), 0);

        // 4: engine never completes -> timeouts, then error on entry 0
        start_reset("t4");
        hang = 1'b1;
        release_rst("t4");
        wait_idle("t4");
        exp_q = '{0, 0, 0, 0};
        check_log("t4", 2);
        chk("t4_error", int'(init_error), 1);
        chk("t4_done", int'(init_done), 0);
        chk("t4_eidx", int'(err_index), 0);
        hang = 1'b0;

        // 3: entry 1 always NACKed
        start_reset("t3");
        nack_left[1] = 99;
        release_rst("t3");
        wait_idle("t3");
        exp_q = '{0, 1, 1, 1, 1};
        check_log("t3", 1);
        chk("t3_error", int'(init_error), 1);
        chk("t3_done", int'(init_done), 0);
        chk("t3_eidx", int'(err_index), 1);
        chk("t3_adc", int'(adc_rst_n), 1);

        // 5: start from IDLE after error reruns cleanly; start during WAIT ignored
        nack_left = '{0, 0, 0, 0};
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_err_clr", int'(init_error), 0);
        chk("t5_eidx_clr", int'(err_index), 0);
        chk("t5_busy", int'(init_busy), 1);
        count_hold("t5");
        n = 0;
        while (log_ent.size() < 1 && n < 500) begin
            n++;
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t5");
        exp_q = '{0, 1, 2, 3};
        check_log("t5", 1);
        chk("t5_done", int'(init_done), 1);
        chk("t5_error", int'(init_error), 0);

        // 6: rst during WAIT, stale done lands in RST_HOLD
        start_reset("t6a");
        release_rst("t6a");
        n = 0;
        while ((log_ent.size() < 2 || bcnt != 3) && n < 500) begin
            n++;
            @(posedge clk);
        end
        chk("t6_inflight", bcnt, 3);
        start_reset("t6");
        release_rst("t6");
        wait_idle("t6");
        exp_q = '{0, 1, 2, 3};
        check_log("t6", 1);
        chk("t6_first_lat", log_cyc.size() > 0 ? log_cyc[0] - adc_rise_cyc : -1, 6);
        chk("t6_done", int'(init_done), 1);
        chk("t6_error", int'(init_error), 0);

        chk("req_single", dbl_req, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
